// File: rtl/pa_isa_pkg.sv
// Shared instruction-set definitions for the fetch/parse/issue pipeline:
// slot geometry, field bit positions, the NOP opcode and the decoded
// instruction record carried between stages.
package pa_isa_pkg;

    // Slot and bundle geometry; slot 0 sits in the upper half of a bundle
    localparam int INSTR_W  = 30;
    localparam int BUNDLE_W = 2 * INSTR_W;

    // Field bit positions inside one 30-bit slot
    localparam int FMT_BIT = 29;
    localparam int BR_BIT  = 28;
    localparam int OPC_HI  = 27;
    localparam int OPC_LO  = 21;
    localparam int PRIM_HI = 20;
    localparam int PRIM_LO = 16;
    localparam int SEC_HI  = 15;
    localparam int SEC_LO  = 11;
    localparam int IMM_HI  = 15;
    localparam int IMM_LO  = 0;

    // Opcode that marks an empty slot, whatever the format bit says
    localparam logic [6:0] NOP_OPCODE = 7'd0;

    // Decoded view of one slot; unused operand fields are forced to zero
    typedef struct packed {
        logic        fmt;      // 1 = reg-imm, 0 = reg-reg
        logic        branch;
        logic [6:0]  opcode;
        logic [4:0]  prim_reg;
        logic [4:0]  sec_reg;
        logic [15:0] imm;
    } decoded_t;

    // A slot carries a real instruction unless its opcode is the NOP code
    function automatic logic slot_is_live(input logic [INSTR_W-1:0] slot);
        return (slot[OPC_HI:OPC_LO] != NOP_OPCODE);
    endfunction

endpackage

// File: rtl/slot_decoder.sv
// Purely combinational field extraction for one 30-bit instruction slot.
// Reg-imm slots expose the immediate and zero the second register;
// reg-reg slots expose the second register and zero the immediate, so
// bits [10:0] of a reg-reg slot never reach the outputs.
module slot_decoder
    import pa_isa_pkg::*;
(
    input  logic [INSTR_W-1:0] slot,
    output decoded_t           fields,
    output logic               live
);

    // Split the slot into its fields and flag whether it is a real instruction
    always_comb begin
        fields          = '0;
        fields.fmt      = slot[FMT_BIT];
        fields.branch   = slot[BR_BIT];
        fields.opcode   = slot[OPC_HI:OPC_LO];
        fields.prim_reg = slot[PRIM_HI:PRIM_LO];
        if (slot[FMT_BIT]) begin
            fields.sec_reg = 5'd0;
            fields.imm     = slot[IMM_HI:IMM_LO];
        end else begin
            fields.sec_reg = slot[SEC_HI:SEC_LO];
            fields.imm     = 16'd0;
        end
        live = slot_is_live(slot);
    end

endmodule

// File: rtl/parse_stage.sv
// Parse stage: takes two-instruction bundles from fetch, drops NOP slots,
// decodes fields and issues at most one instruction per cycle. A second
// live slot waits in a one-entry pending register, and while it waits (or
// while the issued instruction is held by a downstream stall) fetch is
// back-pressured through stall_o.
module parse_stage
    import pa_isa_pkg::*;
(
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                flushBack_i,
    input  logic [BUNDLE_W-1:0] data_i,
    input  logic                enable_i,
    output logic                stall_o,
    input  logic                stall_i,
    output logic                valid_o,
    output logic                format_o,
    output logic                branch_o,
    output logic [6:0]          opcode_o,
    output logic [4:0]          prim_reg_o,
    output logic [4:0]          sec_reg_o,
    output logic [15:0]         imm_o,
    output logic                slot_o
);

    // Raw slots of the incoming bundle
    logic [INSTR_W-1:0] slot0_s;
    logic [INSTR_W-1:0] slot1_s;

    // Decoded views of both bundle slots and of the pending slot
    decoded_t dec0_s;
    decoded_t dec1_s;
    decoded_t dec_pend_s;
    logic     live0_s;
    logic     live1_s;
    logic     live_pend_s;

    // Output register and pending-slot register
    decoded_t           out_r;
    logic               valid_r;
    logic               slot_r;
    logic [INSTR_W-1:0] pend_r;
    logic               pend_valid_r;

    // Next-state values
    decoded_t           out_nxt_s;
    logic               valid_nxt_s;
    logic               slot_nxt_s;
    logic [INSTR_W-1:0] pend_nxt_s;
    logic               pend_valid_nxt_s;

    // Handshake terms
    logic stall_s;
    logic accept_s;
    logic advance_s;

    assign slot0_s = data_i[BUNDLE_W-1:INSTR_W];
    assign slot1_s = data_i[INSTR_W-1:0];

    slot_decoder u_dec_slot0 (
        .slot   (slot0_s),
        .fields (dec0_s),
        .live   (live0_s)
    );

    slot_decoder u_dec_slot1 (
        .slot   (slot1_s),
        .fields (dec1_s),
        .live   (live1_s)
    );

    // The pending slot was already known live when it was parked; its live
    // flag is not needed again.
    slot_decoder u_dec_pend (
        .slot   (pend_r),
        .fields (dec_pend_s),
        .live   (live_pend_s)
    );

    // Back-pressure, bundle acceptance and output-register advance conditions
    always_comb begin
        stall_s   = pend_valid_r | (valid_r & stall_i);
        accept_s  = enable_i & ~stall_s & ~flushBack_i;
        advance_s = ~valid_r | ~stall_i;
    end

    // Select what the output and pending registers load next:
    // flush clears, then pending slot, then first live slot of a new bundle
    always_comb begin
        out_nxt_s        = out_r;
        valid_nxt_s      = valid_r;
        slot_nxt_s       = slot_r;
        pend_nxt_s       = pend_r;
        pend_valid_nxt_s = pend_valid_r;
        if (flushBack_i) begin
            valid_nxt_s      = 1'b0;
            pend_valid_nxt_s = 1'b0;
        end else if (advance_s) begin
            if (pend_valid_r) begin
                out_nxt_s        = dec_pend_s;
                valid_nxt_s      = 1'b1;
                slot_nxt_s       = 1'b1;
                pend_valid_nxt_s = 1'b0;
            end else if (accept_s && live0_s) begin
                out_nxt_s   = dec0_s;
                valid_nxt_s = 1'b1;
                slot_nxt_s  = 1'b0;
                if (live1_s) begin
                    pend_nxt_s       = slot1_s;
                    pend_valid_nxt_s = 1'b1;
                end else begin
                    pend_valid_nxt_s = 1'b0;
                end
            end else if (accept_s && live1_s) begin
                out_nxt_s   = dec1_s;
                valid_nxt_s = 1'b1;
                slot_nxt_s  = 1'b1;
            end else begin
                valid_nxt_s = 1'b0;
            end
        end else begin
            // Downstream is holding the current instruction: keep everything
            out_nxt_s        = out_r;
            valid_nxt_s      = valid_r;
            pend_valid_nxt_s = pend_valid_r;
        end
    end

    // Output and pending registers; reset discards any pending slot at once
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            out_r        <= '0;
            valid_r      <= 1'b0;
            slot_r       <= 1'b0;
            pend_r       <= '0;
            pend_valid_r <= 1'b0;
        end else begin
            out_r        <= out_nxt_s;
            valid_r      <= valid_nxt_s;
            slot_r       <= slot_nxt_s;
            pend_r       <= pend_nxt_s;
            pend_valid_r <= pend_valid_nxt_s;
        end
    end

    assign stall_o    = stall_s;
    assign valid_o    = valid_r;
    assign format_o   = out_r.fmt;
    assign branch_o   = out_r.branch;
    assign opcode_o   = out_r.opcode;
    assign prim_reg_o = out_r.prim_reg;
    assign sec_reg_o  = out_r.sec_reg;
    assign imm_o      = out_r.imm;
    assign slot_o     = slot_r;

endmodule

// File: tb/tb_parse_stage.sv
// Directed test of parse_stage: dual-live, reg-reg + NOP, all-NOP,
// downstream stall, flush and asynchronous reset sequences.
module tb_parse_stage;

    logic        clock_i;
    logic        reset_i;
    logic        flushBack_i;
    logic [59:0] data_i;
    logic        enable_i;
    logic        stall_o;
    logic        stall_i;
    logic        valid_o;
    logic        format_o;
    logic        branch_o;
    logic [6:0]  opcode_o;
    logic [4:0]  prim_reg_o;
    logic [4:0]  sec_reg_o;
    logic [15:0] imm_o;
    logic        slot_o;

    int passed;
    int failed;
    int total;

    parse_stage dut (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .flushBack_i (flushBack_i),
        .data_i      (data_i),
        .enable_i    (enable_i),
        .stall_o     (stall_o),
        .stall_i     (stall_i),
        .valid_o     (valid_o),
        .format_o    (format_o),
        .branch_o    (branch_o),
        .opcode_o    (opcode_o),
        .prim_reg_o  (prim_reg_o),
        .sec_reg_o   (sec_reg_o),
        .imm_o       (imm_o),
        .slot_o      (slot_o)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    // Slot builders
    function automatic logic [29:0] ri(input logic [6:0] opc, input logic [4:0] r, input logic [15:0] imm);
        return {1'b1, 1'b0, opc, r, imm};
    endfunction

    initial begin
        passed      = 0;
        failed      = 0;
        total       = 0;
        reset_i     = 1'b0;
        flushBack_i = 1'b0;
        data_i      = 60'd0;
        enable_i    = 1'b0;
        stall_i     = 1'b0;

        // ---------------- reset state
        tick();
        tick();
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_opcode", 32'(opcode_o), 32'd0);
        check("rst_imm", 32'(imm_o), 32'd0);
        reset_i = 1'b1;
        tick();

        // ---------------- dual live, no stall
        data_i   = {ri(7'h0A, 5'd1, 16'd5), ri(7'h0A, 5'd2, 16'd10)};
        enable_i = 1'b1;
        check("dual_pre_stall", 32'(stall_o), 32'd0);
        tick();
        enable_i = 1'b0;
        check("dual_n1_valid", 32'(valid_o), 32'd1);
        check("dual_n1_opcode", 32'(opcode_o), 32'h0A);
        check("dual_n1_prim", 32'(prim_reg_o), 32'd1);
        check("dual_n1_imm", 32'(imm_o), 32'd5);
        check("dual_n1_sec", 32'(sec_reg_o), 32'd0);
        check("dual_n1_fmt", 32'(format_o), 32'd1);
        check("dual_n1_slot", 32'(slot_o), 32'd0);
        check("dual_n1_stall", 32'(stall_o), 32'd1);
        tick();
        check("dual_n2_valid", 32'(valid_o), 32'd1);
        check("dual_n2_prim", 32'(prim_reg_o), 32'd2);
        check("dual_n2_imm", 32'(imm_o), 32'd10);
        check("dual_n2_slot", 32'(slot_o), 32'd1);
        check("dual_n2_stall", 32'(stall_o), 32'd0);
        tick();
        check("dual_n3_valid", 32'(valid_o), 32'd0);

        // ---------------- reg-reg + NOP
        data_i   = {1'b0, 1'b0, 7'd2, 5'd1, 5'd2, 11'h7FF, 30'd0};
        enable_i = 1'b1;
        check("rr_pre_stall", 32'(stall_o), 32'd0);
        tick();
        enable_i = 1'b0;
        check("rr_valid", 32'(valid_o), 32'd1);
        check("rr_fmt", 32'(format_o), 32'd0);
        check("rr_opcode", 32'(opcode_o), 32'd2);
        check("rr_prim", 32'(prim_reg_o), 32'd1);
        check("rr_sec", 32'(sec_reg_o), 32'd2);
        check("rr_imm", 32'(imm_o), 32'd0);
        check("rr_slot", 32'(slot_o), 32'd0);
        check("rr_stall", 32'(stall_o), 32'd0);
        tick();
        check("rr_done_valid", 32'(valid_o), 32'd0);
        check("rr_done_stall", 32'(stall_o), 32'd0);

        // ---------------- NOP in slot 0, live branch in slot 1
        data_i   = {30'd0, {1'b1, 1'b1, 7'h11, 5'd9, 16'hBEEF}};
        enable_i = 1'b1;
        tick();
        enable_i = 1'b0;
        check("s1_valid", 32'(valid_o), 32'd1);
        check("s1_slot", 32'(slot_o), 32'd1);
        check("s1_branch", 32'(branch_o), 32'd1);
        check("s1_imm", 32'(imm_o), 32'hBEEF);
        check("s1_stall", 32'(stall_o), 32'd0);
        tick();
        check("s1_done_valid", 32'(valid_o), 32'd0);

        // ---------------- all-NOP bundle
        data_i   = {ri(7'd0, 5'd0, 16'd0), ri(7'd0, 5'd0, 16'd0)};
        enable_i = 1'b1;
        tick();
        enable_i = 1'b0;
        check("nop_valid", 32'(valid_o), 32'd0);
        check("nop_stall", 32'(stall_o), 32'd0);
        tick();
        check("nop_valid2", 32'(valid_o), 32'd0);

        // ---------------- downstream stall
        data_i   = {ri(7'h15, 5'd3, 16'd7), ri(7'h15, 5'd4, 16'd9)};
        enable_i = 1'b1;
        tick();
        check("dst_n1_prim", 32'(prim_reg_o), 32'd3);
        check("dst_n1_stall", 32'(stall_o), 32'd1);
        stall_i  = 1'b1;
        data_i   = {ri(7'h33, 5'd7, 16'd1), ri(7'h33, 5'd8, 16'd2)};
        enable_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            enable_i = 1'b0;
            check("dst_hold_valid", 32'(valid_o), 32'd1);
            check("dst_hold_prim", 32'(prim_reg_o), 32'd3);
            check("dst_hold_imm", 32'(imm_o), 32'd7);
            check("dst_hold_slot", 32'(slot_o), 32'd0);
            check("dst_hold_stall", 32'(stall_o), 32'd1);
        end
        stall_i = 1'b0;
        check("dst_release_stall", 32'(stall_o), 32'd1);
        tick();
        check("dst_s1_valid", 32'(valid_o), 32'd1);
        check("dst_s1_opcode", 32'(opcode_o), 32'h15);
        check("dst_s1_prim", 32'(prim_reg_o), 32'd4);
        check("dst_s1_imm", 32'(imm_o), 32'd9);
        check("dst_s1_slot", 32'(slot_o), 32'd1);
        check("dst_s1_stall", 32'(stall_o), 32'd0);
        tick();
        check("dst_ignored_valid", 32'(valid_o), 32'd0);

        // ---------------- flush
        data_i   = {ri(7'h21, 5'd5, 16'd11), ri(7'h21, 5'd6, 16'd12)};
        enable_i = 1'b1;
        tick();
        check("fl_n1_valid", 32'(valid_o), 32'd1);
        flushBack_i = 1'b1;
        data_i      = {ri(7'h22, 5'd7, 16'd13), ri(7'h22, 5'd8, 16'd14)};
        enable_i    = 1'b1;
        tick();
        flushBack_i = 1'b0;
        enable_i    = 1'b0;
        check("fl_valid", 32'(valid_o), 32'd0);
        check("fl_stall", 32'(stall_o), 32'd0);
        tick();
        check("fl_after_valid", 32'(valid_o), 32'd0);
        check("fl_after_stall", 32'(stall_o), 32'd0);

        // ---------------- asynchronous reset with a slot pending
        data_i   = {ri(7'h30, 5'd9, 16'd21), ri(7'h30, 5'd10, 16'd22)};
        enable_i = 1'b1;
        tick();
        enable_i = 1'b0;
        check("ar_pre_valid", 32'(valid_o), 32'd1);
        check("ar_pre_stall", 32'(stall_o), 32'd1);
        #2;
        reset_i = 1'b0;
        #1;
        check("ar_valid", 32'(valid_o), 32'd0);
        check("ar_stall", 32'(stall_o), 32'd0);
        check("ar_opcode", 32'(opcode_o), 32'd0);
        check("ar_prim", 32'(prim_reg_o), 32'd0);
        check("ar_imm", 32'(imm_o), 32'd0);
        tick();
        reset_i = 1'b1;
        tick();
        check("ar_rel_valid", 32'(valid_o), 32'd0);
        check("ar_rel_stall", 32'(stall_o), 32'd0);
        tick();
        check("ar_rel_valid2", 32'(valid_o), 32'd0);
        data_i   = {ri(7'h31, 5'd12, 16'd33), 30'd0};
        enable_i = 1'b1;
        tick();
        enable_i = 1'b0;
        check("ar_new_valid", 32'(valid_o), 32'd1);
        check("ar_new_prim", 32'(prim_reg_o), 32'd12);
        check("ar_new_imm", 32'(imm_o), 32'd33);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/parse_stage.md
Name: parse_stage

Overview:
- Stage-1 consumer of the fetch interface: accepts 60-bit two-instruction bundles (`data_i` / `enable_i`) and splits them into two 30-bit slots.
- Drops NOP slots, decodes instruction fields, and issues one instruction per cycle to the dependency/issue logic.
- Drives the `stall_o` back-pressure line that fetch samples as its stall input; honours `flushBack_i` from the branch path.

Parameters:
- `INSTR_W`, 30, width of one instruction slot.
- `BUNDLE_W`, 60, fetch bundle width (2*`INSTR_W`); slot 0 = [59:30], slot 1 = [29:0].
- `NOP_OPCODE`, 7'd0, opcode value treated as an empty slot regardless of format bit.

Ports:
- `clock_i`  in  1  single clock, rising edge.
- `reset_i`  in  1  asynchronous, active-low reset.
- `flushBack_i`  in  1  synchronous flush from branch resolution.
- `data_i`  in  60  bundle from fetch.
- `enable_i`  in  1  one-cycle pulse: `data_i` holds a new bundle.
- `stall_o`  out  1  back-pressure to fetch; combinational.
- `stall_i`  in  1  downstream (dependency unit) stall.
- `valid_o`  out  1  decoded instruction present.
- `format_o`  out  1  1 = reg-imm, 0 = reg-reg (slot bit 29).
- `branch_o`  out  1  branch flag (bit 28).
- `opcode_o`  out  7  bits 27:21.
- `prim_reg_o`  out  5  bits 20:16.
- `sec_reg_o`  out  5  bits 15:11; driven 0 when `format_o`=1.
- `imm_o`  out  16  bits 15:0; driven 0 when `format_o`=0.
- `slot_o`  out  1  0 = came from slot 0, 1 = slot 1.

Behaviour:
- Storage: one output register (all `*_o` decode fields plus `valid_o`) and one pending-slot register (`pend_valid`, 30-bit raw slot).
- Reset (`reset_i`=0, async): `valid_o`=0, `pend_valid`=0, all field outputs 0, `stall_o` then evaluates 0.
- `stall_o` = `pend_valid` | (`valid_o` & `stall_i`).
- Accept = `enable_i` & !`stall_o` & !`flushBack_i`. A bundle presented while `stall_o`=1 is not captured; fetch must not advance PC in that cycle.
- Slot is live iff opcode != `NOP_OPCODE`.
- Advance = !`valid_o` | !`stall_i`. On advance, the output register loads, in priority order:
  - (1) the pending slot: `slot_o`=1, `pend_valid`<=0;
  - (2) otherwise, if accept: the first live slot. If both slots are live, slot 0 goes out and slot 1 goes to pending (`pend_valid`<=1). If only slot 1 is live, it goes out with `slot_o`=1;
  - (3) otherwise `valid_o`<=0.
- Not advancing (`valid_o` & `stall_i`): all outputs and pending hold unchanged.
- Latency: accept at edge N gives `valid_o` at N+1. A dual-live bundle issues its slot 1 at N+2 if `stall_i`=0.
- Throughput: one single-live bundle per cycle. A dual-live bundle holds `stall_o` high for 1 cycle minimum.
- All-NOP bundle: accepted, produces no `valid_o`, no stall.
- `flushBack_i`=1 (sync, highest priority after reset): `valid_o`<=0, `pend_valid`<=0, incoming bundle dropped regardless of `stall_i`.
- Reset asserted mid-pair: pending discarded immediately (async); no residual issue after release.
- Field decode is purely on the selected 30-bit slot; no arithmetic. Unused field bits [10:0] of reg-reg slots are ignored.

Decomposition:
- Shared package `pa_isa_pkg`: `INSTR_W`, `BUNDLE_W`, bit positions (`FMT_BIT`=29, `BR_BIT`=28, `OPC_HI`/`LO`=27/21, `PRIM_HI`/`LO`=20/16, `SEC_HI`/`LO`=15/11, `IMM_HI`/`LO`=15/0), `NOP_OPCODE`, and a decoded-instruction struct. Fetch and later stages reuse it.
- One sub-module: `slot_decoder` (combinational 30-bit slot -> fields + live flag), instantiated twice for the bundle and once for the pending slot (or muxed before one instance).

Test Plan:
- Dual live: bundle `1_0_0001010_00001_0000000000000101__1_0_0001010_00010_0000000000001010`, `enable_i` pulse, `stall_i`=0.
  - N+1: `valid_o`=1, `opcode_o`=0x0A, `prim_reg_o`=1, `imm_o`=5, `slot_o`=0, `stall_o`=1.
  - N+2: `prim_reg_o`=2, `imm_o`=10, `slot_o`=1, `stall_o`=0.
  - N+3: `valid_o`=0.
- Reg-reg + NOP: `0_0_0000010_00001_00010_00000000000__` followed by 30 zeros.
  - Single issue: `format_o`=0, `opcode_o`=2, `prim_reg_o`=1, `sec_reg_o`=2, `imm_o`=0.
  - `stall_o` never 1.
- All-NOP: `1_0_0000000_00000_0000000000000000` repeated in both slots, `enable_i` pulse.
  - `valid_o` stays 0 and `stall_o` stays 0.
- Downstream stall: dual-live bundle with `stall_i`=1 for 3 cycles from N+1.
  - Slot-0 outputs held 3 cycles, `stall_o`=1 throughout.
  - A second `enable_i` pulse presented during the stall is ignored.
  - Slot 1 appears on the cycle after `stall_i` falls.
- Flush: dual-live bundle, `flushBack_i`=1 at N+1 together with a new bundle.
  - N+2: `valid_o`=0, `pend_valid`=0, `stall_o`=0; the new bundle is not issued.
- Async reset: drive `reset_i` low mid-cycle while a slot is pending.
  - Outputs go to 0 before the next clock edge.
  - After release, no issue occurs until the next `enable_i` pulse.
